// File: rtl/serial_sub_6bit.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_sub_6bit #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic             bit_diff;
    logic             bit_bout;
    logic [WIDTH-1:0] diff_shift;

    always_comb begin
        bit_diff = a_q[0] ^ b_q[0] ^ borrow_q;
        bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_shift            = diff_q >> 1;
        diff_shift[WIDTH-1]   = bit_diff;

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d      = i_minuend;
                    b_d      = i_subtrahend;
                    diff_d   = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = diff_shift;
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    result_d = {bit_bout, diff_shift};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_serial_sub_6bit.sv
// Directed and randomized checks for serial_sub_6bit with hand-computed results.
module tb_serial_sub_6bit;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [5:0] i_minuend;
    logic [5:0] i_subtrahend;
    logic       o_valid;
    logic       i_ready;
    logic [6:0] o_result;

    int total;
    int bad;

    serial_sub_6bit #(.WIDTH(6)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_minuend   (i_minuend),
        .i_subtrahend(i_subtrahend),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Called at posedge+1 with the block idle; returns at posedge+1 with o_valid seen (or timeout).
    task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                          output logic [6:0] res, output int lat);
        i_minuend    = a;
        i_subtrahend = b;
        i_valid      = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        res = o_result;
    endtask

    task automatic test_reset();
        i_rst_n      = 1'b1;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_minuend    = '0;
        i_subtrahend = '0;
        #3;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        total++;
        if (o_result !== 7'h00) begin
            bad++;
            $display("FAIL reset_result: got %h want 00", o_result);
        end
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic();
        logic [6:0] res;
        int         lat;
        i_ready = 1'b1;
        i_minuend    = 6'd45;
        i_subtrahend = 6'd18;
        i_valid      = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        total++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_flags: got ready=%b valid=%b want 0 0", o_ready, o_valid);
        end
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        res = o_result;
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 6", lat);
        end
        total++;
        if (res !== 7'h1B || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got %h ready=%b want 1b ready=0", res, o_ready);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_return: got ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_borrow();
        logic [5:0] va [4] = '{6'd5, 6'd0, 6'd63, 6'd0};
        logic [5:0] vb [4] = '{6'd9, 6'd1, 6'd63, 6'd0};
        logic [6:0] ve [4] = '{7'h7C, 7'h7F, 7'h00, 7'h00};
        logic [6:0] res;
        int         lat;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], res, lat);
            total++;
            if (res !== ve[i] || lat !== 6) begin
                bad++;
                $display("FAIL borrow_vec%0d: got %h lat=%0d want %h lat=6", i, res, lat, ve[i]);
            end
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] res;
        int         lat;
        i_ready = 1'b0;
        run_op(6'd20, 6'd7, res, lat);
        total++;
        if (res !== 7'h0D || o_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_result: got %h valid=%b want 0d valid=1", res, o_valid);
        end
        for (int i = 0; i < 10; i++) begin
            i_valid      = ~i_valid;
            i_minuend    = 6'($urandom_range(0, 63));
            i_subtrahend = 6'($urandom_range(0, 63));
            @(posedge i_clk);
            #1;
            total++;
            if (o_result !== 7'h0D || o_valid !== 1'b1 || o_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got %h valid=%b ready=%b want 0d 1 0",
                         i, o_result, o_valid, o_ready);
            end
        end
        // i_valid high on the output handshake edge must not start a new operation.
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 7'h0D) begin
            bad++;
            $display("FAIL bp_release: got ready=%b valid=%b res=%h want 1 0 0d",
                     o_ready, o_valid, o_result);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL no_accept_on_out_hs: got ready=%b want 1", o_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [6:0] res;
        int         lat;
        bit         seen_valid;
        i_ready      = 1'b1;
        i_minuend    = 6'd45;
        i_subtrahend = 6'd18;
        i_valid      = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #4;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 7'h00) begin
            bad++;
            $display("FAIL midbusy_reset: got ready=%b valid=%b res=%h want 1 0 00",
                     o_ready, o_valid, o_result);
        end
        #2;
        i_rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid) begin
            bad++;
            $display("FAIL midbusy_no_valid: got valid pulse after reset want none");
        end
        run_op(6'd10, 6'd3, res, lat);
        total++;
        if (res !== 7'h07 || lat !== 6) begin
            bad++;
            $display("FAIL after_reset_op: got %h lat=%0d want 07 lat=6", res, lat);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_q[$];
        logic [5:0] a;
        logic [5:0] b;
        logic [6:0] exp_v;
        int         sent;
        int         recv;
        int         cycles;
        sent   = 0;
        recv   = 0;
        cycles = 0;
        a = 6'($urandom_range(0, 63));
        b = 6'($urandom_range(0, 63));
        i_minuend    = a;
        i_subtrahend = b;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        while (recv < 1000 && cycles < 40000) begin
            @(negedge i_clk);
            // Inputs only change just after posedge, so these predict the next edge.
            if (o_valid && i_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: got %h with no pending pair", o_result);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (o_result !== exp_v) begin
                        bad++;
                        $display("FAIL b2b_result%0d: got %h want %h", recv, o_result, exp_v);
                    end
                end
                recv++;
            end
            if (i_valid && o_ready && sent < 1000) begin
                exp_q.push_back({a < b, 6'(a - b)});
                sent++;
                a = 6'($urandom_range(0, 63));
                b = 6'($urandom_range(0, 63));
            end
            @(posedge i_clk);
            #1;
            cycles++;
            i_minuend    = a;
            i_subtrahend = b;
            i_valid      = (sent < 1000) && ($urandom_range(0, 9) < 7);
            i_ready      = ($urandom_range(0, 9) < 6);
        end
        i_valid = 1'b0;
        total++;
        if (recv !== 1000 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count: got recv=%0d pending=%0d want 1000 0", recv, exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
